decode_regfile: RTL and testbench

Decode-stage register file and scoreboard: the receiving end of the writeback port (enable / register index / data) driven by the writeback stage. It holds the 16 architectural registers and supplies two source operands with same-cycle write bypass. A per-register pending-write counter generates the dependency stall that decode forwards down the pipeline.

---
 rtl/decode_regfile_pkg.sv | 21 ++
 rtl/decode_regfile_reg_scoreboard.sv | 86 ++++++++
 rtl/decode_regfile.sv | 77 +++++++
 tb/tb_decode_regfile.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_regfile_pkg.sv
// Shared decode-stage constants: register file geometry and scoreboard counter limits.
package decode_regfile_pkg;

  localparam int DEF_REG_WIDTH = 16;
  localparam int DEF_NUM_REGS  = 16;
  localparam int DEF_IDX_WIDTH = 4;
  localparam int DEF_CNT_WIDTH = 2;
  localparam int DEF_CNT_MAX   = (1 << DEF_CNT_WIDTH) - 1;

  // One source or destination reference carried by a decoded instruction.
  typedef struct packed {
    logic                     valid;
    logic [DEF_IDX_WIDTH-1:0] idx;
  } regRef_t;

  function automatic logic idxMatch(input logic [DEF_IDX_WIDTH-1:0] a,
                                    input logic [DEF_IDX_WIDTH-1:0] b);
    return a == b;
  endfunction

endpackage

// File: rtl/decode_regfile_reg_scoreboard.sv
// Per-register pending-write counters, dependency stall generation and the sticky
// scoreboard error flag for the decode-stage register file.
module reg_scoreboard
  import decode_regfile_pkg::*;
#(
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int IDX_WIDTH = DEF_IDX_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 lock,
  input  logic                 wbEnable,
  input  logic [IDX_WIDTH-1:0] wbIdx,
  input  logic                 issueValid,
  input  logic                 src1Valid,
  input  logic [IDX_WIDTH-1:0] src1Idx,
  input  logic                 src2Valid,
  input  logic [IDX_WIDTH-1:0] src2Idx,
  input  logic                 destValid,
  input  logic [IDX_WIDTH-1:0] destIdx,
  output logic                 depStall,
  output logic [NUM_REGS-1:0]  pending,
  output logic                 scoreboardErr
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt     [NUM_REGS];
  logic [CNT_WIDTH-1:0] cntNext [NUM_REGS];
  logic [CNT_WIDTH-1:0] eff     [NUM_REGS];
  logic [NUM_REGS-1:0]  wbDec;
  logic [NUM_REGS-1:0]  issueInc;
  logic                 src1Busy;
  logic                 src2Busy;
  logic                 destFull;
  logic                 issueFire;
  logic                 errSet;

  // eff[] is the count as it will stand after this cycle's commit, so an
  // instruction waiting on the last outstanding write issues in the commit cycle.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      wbDec[i] = lock && wbEnable && (wbIdx == IDX_WIDTH'(i));
      eff[i]   = cnt[i] - (wbDec[i] ? CNT_ONE : '0);
    end
  end

  always_comb begin
    src1Busy  = src1Valid && (eff[src1Idx] != '0);
    src2Busy  = src2Valid && (eff[src2Idx] != '0);
    destFull  = destValid && (cnt[destIdx] == CNT_MAX) && !wbDec[destIdx];
    depStall  = lock && issueValid && (src1Busy || src2Busy || destFull);
    issueFire = lock && issueValid && destValid && !depStall;
  end

  always_comb begin
    errSet = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      issueInc[i] = issueFire && (destIdx == IDX_WIDTH'(i));
      cntNext[i]  = cnt[i];
      if (issueInc[i] && !wbDec[i]) begin
        if (cnt[i] != CNT_MAX) cntNext[i] = cnt[i] + CNT_ONE;
      end else if (!issueInc[i] && wbDec[i]) begin
        if (cnt[i] == '0) errSet = 1'b1;
        else              cntNext[i] = cnt[i] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
      scoreboardErr <= 1'b0;
    end else if (lock) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= cntNext[i];
      if (errSet) scoreboardErr <= 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) pending[i] = (cnt[i] != '0);
  end

endmodule

// File: rtl/decode_regfile.sv
// Decode-stage register file: architectural data array with same-cycle writeback
// bypass on both source read ports, plus the pending-write scoreboard.
module decode_regfile
  import decode_regfile_pkg::*;
#(
  parameter int REG_WIDTH = DEF_REG_WIDTH,
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int IDX_WIDTH = DEF_IDX_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 I_CLOCK,
  input  logic                 I_RESET,
  input  logic                 I_LOCK,
  input  logic                 I_WriteBackEnable,
  input  logic [IDX_WIDTH-1:0] I_WriteBackRegIdx,
  input  logic [REG_WIDTH-1:0] I_WriteBackData,
  input  logic                 I_IssueValid,
  input  logic                 I_Src1Valid,
  input  logic                 I_Src2Valid,
  input  logic [IDX_WIDTH-1:0] I_Src1Idx,
  input  logic [IDX_WIDTH-1:0] I_Src2Idx,
  input  logic                 I_DestValid,
  input  logic [IDX_WIDTH-1:0] I_DestIdx,
  output logic [REG_WIDTH-1:0] O_Src1Data,
  output logic [REG_WIDTH-1:0] O_Src2Data,
  output logic                 O_DepStall,
  output logic [NUM_REGS-1:0]  O_Pending,
  output logic                 O_ScoreboardErr
);

  // Issue handshake: an instruction presented with I_IssueValid is accepted on
  // a rising edge where I_LOCK is high and O_DepStall is low; otherwise decode
  // must hold it unchanged. Writebacks are never back-pressured.

  logic [REG_WIDTH-1:0] regs [NUM_REGS];
  logic                 wbFire;

  assign wbFire = I_LOCK && I_WriteBackEnable;

  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wbFire) begin
      regs[I_WriteBackRegIdx] <= I_WriteBackData;
    end
  end

  always_comb begin
    O_Src1Data = (wbFire && (I_WriteBackRegIdx == I_Src1Idx)) ? I_WriteBackData
                                                               : regs[I_Src1Idx];
    O_Src2Data = (wbFire && (I_WriteBackRegIdx == I_Src2Idx)) ? I_WriteBackData
                                                               : regs[I_Src2Idx];
  end

  reg_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .IDX_WIDTH (IDX_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_scoreboard (
    .clock         (I_CLOCK),
    .reset         (I_RESET),
    .lock          (I_LOCK),
    .wbEnable      (I_WriteBackEnable),
    .wbIdx         (I_WriteBackRegIdx),
    .issueValid    (I_IssueValid),
    .src1Valid     (I_Src1Valid),
    .src1Idx       (I_Src1Idx),
    .src2Valid     (I_Src2Valid),
    .src2Idx       (I_Src2Idx),
    .destValid     (I_DestValid),
    .destIdx       (I_DestIdx),
    .depStall      (O_DepStall),
    .pending       (O_Pending),
    .scoreboardErr (O_ScoreboardErr)
  );

endmodule

// File: tb/tb_decode_regfile.sv
// Directed-vector bench for decode_regfile: bypass, RAW stall, counter saturation,
// same-cycle issue/commit, lock hold and sticky error/reset behaviour.
module tb_decode_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        lock;
  logic        wbEn;
  logic [3:0]  wbIdx;
  logic [15:0] wbData;
  logic        issueValid;
  logic        src1Valid, src2Valid;
  logic [3:0]  src1Idx, src2Idx;
  logic        destValid;
  logic [3:0]  destIdx;
  logic [15:0] src1Data, src2Data;
  logic        depStall;
  logic [15:0] pending;
  logic        sbErr;

  int n_vec = 0;
  int n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  decode_regfile dut (
    .I_CLOCK           (clk),
    .I_RESET           (rst),
    .I_LOCK            (lock),
    .I_WriteBackEnable (wbEn),
    .I_WriteBackRegIdx (wbIdx),
    .I_WriteBackData   (wbData),
    .I_IssueValid      (issueValid),
    .I_Src1Valid       (src1Valid),
    .I_Src2Valid       (src2Valid),
    .I_Src1Idx         (src1Idx),
    .I_Src2Idx         (src2Idx),
    .I_DestValid       (destValid),
    .I_DestIdx         (destIdx),
    .O_Src1Data        (src1Data),
    .O_Src2Data        (src2Data),
    .O_DepStall        (depStall),
    .O_Pending         (pending),
    .O_ScoreboardErr   (sbErr)
  );

  // driver tasks
  task automatic clear_inputs();
    rst = 1'b0; lock = 1'b1; wbEn = 1'b0; wbIdx = '0; wbData = '0;
    issueValid = 1'b0; src1Valid = 1'b0; src2Valid = 1'b0;
    src1Idx = '0; src2Idx = '0; destValid = 1'b0; destIdx = '0;
  endtask

  // advance one edge, then leave #1 so registered outputs have settled
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue_dest(input logic [3:0] d);
    issueValid = 1'b1; destValid = 1'b1; destIdx = d;
  endtask

  task automatic drive_wb(input logic [3:0] idx, input logic [15:0] data);
    wbEn = 1'b1; wbIdx = idx; wbData = data;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      src1Idx = 4'(i); src2Idx = 4'(15 - i);
      #1;
      n_vec++;
      if (src1Data !== 16'h0000) begin
        n_err++; $display("FAIL reset_src1 R%0d: got %h want 0000", i, src1Data);
      end
      n_vec++;
      if (src2Data !== 16'h0000) begin
        n_err++; $display("FAIL reset_src2 R%0d: got %h want 0000", 15 - i, src2Data);
      end
    end
    n_vec++;
    if (depStall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", depStall); end
    n_vec++;
    if (pending !== 16'h0000) begin n_err++; $display("FAIL reset_pending: got %h want 0000", pending); end
    n_vec++;
    if (sbErr !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", sbErr); end
  endtask

  task automatic test_bypass();
    clear_inputs();
    drive_issue_dest(4'd3);
    #1;
    n_vec++;
    if (depStall !== 1'b0) begin n_err++; $display("FAIL bypass_issue_stall: got %b want 0", depStall); end
    next_cycle();
    clear_inputs();
    n_vec++;
    if (pending !== 16'h0008) begin n_err++; $display("FAIL bypass_pending: got %h want 0008", pending); end
    drive_wb(4'd3, 16'h1234);
    src1Valid = 1'b1; src1Idx = 4'd3;
    #1;
    n_vec++;
    if (src1Data !== 16'h1234) begin n_err++; $display("FAIL bypass_same_cycle: got %h want 1234", src1Data); end
    next_cycle();
    wbEn = 1'b0; wbData = 16'hFFFF;
    #1;
    n_vec++;
    if (src1Data !== 16'h1234) begin n_err++; $display("FAIL bypass_array_next: got %h want 1234", src1Data); end
    n_vec++;
    if (pending !== 16'h0000) begin n_err++; $display("FAIL bypass_pending_clr: got %h want 0000", pending); end
    n_vec++;
    if (sbErr !== 1'b0) begin n_err++; $display("FAIL bypass_err: got %b want 0", sbErr); end
  endtask

  task automatic test_raw_stall();
    clear_inputs();
    drive_issue_dest(4'd5);
    next_cycle();
    clear_inputs();
    issueValid = 1'b1; src2Valid = 1'b1; src2Idx = 4'd5;
    #1;
    n_vec++;
    if (depStall !== 1'b1) begin n_err++; $display("FAIL raw_stall: got %b want 1", depStall); end
    n_vec++;
    if (pending[5] !== 1'b1) begin n_err++; $display("FAIL raw_pending5: got %b want 1", pending[5]); end
    next_cycle();
    drive_wb(4'd5, 16'h00AA);
    #1;
    n_vec++;
    if (depStall !== 1'b0) begin n_err++; $display("FAIL raw_release: got %b want 0", depStall); end
    n_vec++;
    if (src2Data !== 16'h00AA) begin n_err++; $display("FAIL raw_src2_bypass: got %h want 00aa", src2Data); end
    next_cycle();
    clear_inputs();
    n_vec++;
    if (pending[5] !== 1'b0) begin n_err++; $display("FAIL raw_pending5_clr: got %b want 0", pending[5]); end
  endtask

  task automatic test_back_to_back();
    logic expStall [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      drive_issue_dest(4'd7);
      #1;
      n_vec++;
      if (depStall !== expStall[k]) begin
        n_err++; $display("FAIL b2b_issue%0d_stall: got %b want %b", k, depStall, expStall[k]);
      end
      if (k < 3) next_cycle();
    end
    // fourth issue is still presented; a commit to R7 in this cycle frees it
    drive_wb(4'd7, 16'h7777);
    #1;
    n_vec++;
    if (depStall !== 1'b0) begin n_err++; $display("FAIL b2b_wb_release: got %b want 0", depStall); end
    next_cycle();
    clear_inputs();
    drive_issue_dest(4'd7);
    #1;
    n_vec++;
    if (depStall !== 1'b1) begin n_err++; $display("FAIL b2b_still_full: got %b want 1", depStall); end
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (pending[7] !== 1'b1) begin n_err++; $display("FAIL b2b_drain%0d_pending: got %b want 1", k, pending[7]); end
      drive_wb(4'd7, 16'(16'h0700 + k));
      next_cycle();
    end
    clear_inputs();
    n_vec++;
    if (pending[7] !== 1'b0) begin n_err++; $display("FAIL b2b_drained: got %b want 0", pending[7]); end
    n_vec++;
    if (sbErr !== 1'b0) begin n_err++; $display("FAIL b2b_err: got %b want 0", sbErr); end
    src1Idx = 4'd7;
    #1;
    n_vec++;
    if (src1Data !== 16'h0702) begin n_err++; $display("FAIL b2b_last_data: got %h want 0702", src1Data); end
  endtask

  task automatic test_same_cycle();
    clear_inputs();
    drive_issue_dest(4'd2);
    next_cycle();
    drive_issue_dest(4'd2);
    drive_wb(4'd2, 16'h2222);
    #1;
    n_vec++;
    if (depStall !== 1'b0) begin n_err++; $display("FAIL same_stall: got %b want 0", depStall); end
    next_cycle();
    clear_inputs();
    n_vec++;
    if (pending[2] !== 1'b1) begin n_err++; $display("FAIL same_pending: got %b want 1", pending[2]); end
    n_vec++;
    if (sbErr !== 1'b0) begin n_err++; $display("FAIL same_err: got %b want 0", sbErr); end
    drive_wb(4'd2, 16'h2223);
    next_cycle();
    clear_inputs();
    n_vec++;
    if (pending[2] !== 1'b0) begin n_err++; $display("FAIL same_cnt_one: got %b want 0", pending[2]); end
    n_vec++;
    if (sbErr !== 1'b0) begin n_err++; $display("FAIL same_err_after: got %b want 0", sbErr); end
  endtask

  task automatic test_lock();
    clear_inputs();
    drive_issue_dest(4'd6);
    next_cycle();
    clear_inputs();
    lock = 1'b0;
    issueValid = 1'b1; src1Valid = 1'b1; src1Idx = 4'd6;
    destValid = 1'b1; destIdx = 4'd4;
    drive_wb(4'd4, 16'hBEEF);
    src2Idx = 4'd4;
    #1;
    n_vec++;
    if (depStall !== 1'b0) begin n_err++; $display("FAIL lock_stall: got %b want 0", depStall); end
    n_vec++;
    if (src2Data !== 16'h0000) begin n_err++; $display("FAIL lock_no_bypass: got %h want 0000", src2Data); end
    next_cycle();
    clear_inputs();
    src2Idx = 4'd4;
    #1;
    n_vec++;
    if (src2Data !== 16'h0000) begin n_err++; $display("FAIL lock_no_write: got %h want 0000", src2Data); end
    n_vec++;
    if (pending !== 16'h0040) begin n_err++; $display("FAIL lock_pending: got %h want 0040", pending); end
    n_vec++;
    if (sbErr !== 1'b0) begin n_err++; $display("FAIL lock_err: got %b want 0", sbErr); end
    drive_wb(4'd6, 16'h0606);
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_err_reset();
    clear_inputs();
    drive_wb(4'd9, 16'h5A5A);
    #1;
    n_vec++;
    if (sbErr !== 1'b0) begin n_err++; $display("FAIL err_not_yet: got %b want 0", sbErr); end
    next_cycle();
    clear_inputs();
    src1Idx = 4'd9;
    #1;
    n_vec++;
    if (sbErr !== 1'b1) begin n_err++; $display("FAIL err_set: got %b want 1", sbErr); end
    n_vec++;
    if (src1Data !== 16'h5A5A) begin n_err++; $display("FAIL err_data_written: got %h want 5a5a", src1Data); end
    n_vec++;
    if (pending[9] !== 1'b0) begin n_err++; $display("FAIL err_cnt_zero: got %b want 0", pending[9]); end
    next_cycle();
    n_vec++;
    if (sbErr !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", sbErr); end
    // reset must win over a same-cycle commit and issue
    rst = 1'b1;
    drive_wb(4'd9, 16'hC3C3);
    drive_issue_dest(4'd9);
    next_cycle();
    clear_inputs();
    src1Idx = 4'd9;
    #1;
    n_vec++;
    if (sbErr !== 1'b0) begin n_err++; $display("FAIL err_reset_clr: got %b want 0", sbErr); end
    n_vec++;
    if (src1Data !== 16'h0000) begin n_err++; $display("FAIL err_reset_r9: got %h want 0000", src1Data); end
    n_vec++;
    if (pending !== 16'h0000) begin n_err++; $display("FAIL err_reset_pending: got %h want 0000", pending); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_bypass();
    test_raw_stall();
    test_back_to_back();
    test_same_cycle();
    test_lock();
    test_err_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
